mips150_ctrl_pipe: RTL and testbench

//  Pipelined control unit for the MIPS150 datapath. Decodes a 32-bit instruction in ID and carries its

---
 rtl/mips150_ctrl_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_mips150_ctrl_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips150_ctrl_pipe.sv
// Pipelined MIPS150 control unit: decodes in ID, carries the control word through EX,
// MEM_LAT memory stages and WB, and interlocks on load-use hazards.
module mips150_ctrl_pipe #(
    parameter int MEM_LAT  = 1,
    parameter int RADDR_W  = 5,
    parameter int MASK_W   = 3,
    parameter int LU_STALL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    output logic               id_ready,
    input  logic               mem_busy,
    input  logic               flush,
    output logic               stall,
    output logic               illegal,
    output logic               ex_valid,
    output logic [3:0]         ex_alu_ctrl,
    output logic               ex_sign_or_zero,
    output logic               ex_lui,
    output logic               mem_valid,
    output logic [1:0]         mem_write,
    output logic [MASK_W-1:0]  mem_mask,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [RADDR_W-1:0] wb_dst
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LB    = 6'h20, OP_LH    = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24,
                           OP_LHU   = 6'h25, OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_ADDU = 4'd0, ALU_SUBU = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
                           ALU_AND  = 4'd4, ALU_OR   = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
                           ALU_LUI  = 4'd8, ALU_SLL  = 4'd9, ALU_SRL = 4'd10, ALU_SRA = 4'd11;

    typedef struct packed {
        logic [1:0]         mw;
        logic [MASK_W-1:0]  mask;
        logic               rw;
        logic               m2r;
        logic [RADDR_W-1:0] dst;
    } mem_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       soz;
        logic       lui;
        mem_t       m;
    } ctl_t;

    typedef struct packed {
        logic               rw;
        logic               m2r;
        logic [RADDR_W-1:0] dst;
    } wb_t;

    function automatic logic [3:0] alu_dec(input logic [5:0] funct);
        case (funct)
            6'h20, 6'h21: alu_dec = ALU_ADDU;
            6'h22, 6'h23: alu_dec = ALU_SUBU;
            6'h2A:        alu_dec = ALU_SLT;
            6'h2B:        alu_dec = ALU_SLTU;
            6'h24:        alu_dec = ALU_AND;
            6'h25:        alu_dec = ALU_OR;
            6'h26:        alu_dec = ALU_XOR;
            6'h27:        alu_dec = ALU_NOR;
            6'h00, 6'h04: alu_dec = ALU_SLL;
            6'h02, 6'h06: alu_dec = ALU_SRL;
            6'h03, 6'h07: alu_dec = ALU_SRA;
            default:      alu_dec = ALU_ADDU;
        endcase
    endfunction

    function automatic logic lu_hit(input logic v, input logic m2r, input logic [RADDR_W-1:0] d,
                                    input logic [RADDR_W-1:0] rs, input logic [RADDR_W-1:0] rt);
        lu_hit = v && m2r && (d != '0) && ((d == rs) || (d == rt));
    endfunction

    logic [5:0]         op;
    logic [RADDR_W-1:0] rs, rt, rd;
    ctl_t               dec;
    logic               dec_ill;
    logic               haz, accept;
    logic               unused_shamt;

    logic               vld_p0;
    ctl_t               ctl_p0;
    logic [MEM_LAT-1:0] vld_p1;
    mem_t               ctl_p1 [MEM_LAT];
    logic               vld_p2;
    wb_t                ctl_p2;

    assign op           = instr[31:26];
    assign rs           = RADDR_W'(instr[25:21]);
    assign rt           = RADDR_W'(instr[20:16]);
    assign rd           = RADDR_W'(instr[15:11]);
    assign unused_shamt = ^instr[10:6];

    // ID: decode
    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec.m.rw  = 1'b1;
                dec.m.dst = rd;
                dec.alu   = alu_dec(instr[5:0]);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.m.rw  = 1'b1;
                dec.m.m2r = 1'b1;
                dec.soz   = 1'b1;
                dec.m.dst = rt;
                case (op)
                    OP_LH:   dec.m.mask = MASK_W'(1);
                    OP_LW:   dec.m.mask = MASK_W'(2);
                    OP_LBU:  dec.m.mask = MASK_W'(3);
                    OP_LHU:  dec.m.mask = MASK_W'(4);
                    default: dec.m.mask = MASK_W'(0);
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.soz   = 1'b1;
                dec.m.dst = rt;
                case (op)
                    OP_SB:   dec.m.mw = 2'b01;
                    OP_SH:   dec.m.mw = 2'b10;
                    default: dec.m.mw = 2'b11;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.m.rw  = 1'b1;
                dec.soz   = 1'b1;
                dec.m.dst = rt;
                dec.alu   = (op == OP_ADDIU) ? ALU_ADDU : (op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.m.rw  = 1'b1;
                dec.m.dst = rt;
                dec.alu   = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
            end
            OP_LUI: begin
                dec.m.rw  = 1'b1;
                dec.lui   = 1'b1;
                dec.m.dst = rt;
                dec.alu   = ALU_LUI;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // The last memory stage is excluded: its load data is forwardable, giving MEM_LAT bubbles.
    always_comb begin
        haz = lu_hit(vld_p0, ctl_p0.m.m2r, ctl_p0.m.dst, rs, rt);
        for (int k = 0; k < MEM_LAT - 1; k++)
            haz = haz | lu_hit(vld_p1[k], ctl_p1[k].m2r, ctl_p1[k].dst, rs, rt);
    end

    assign stall    = (LU_STALL != 0) && instr_valid && haz;
    assign id_ready = !stall && !mem_busy;
    assign accept   = instr_valid && id_ready && !flush;

    // EX / MEM / WB: valid bits (reset) and control words (no reset, gated at the outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= '0;
            vld_p2  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            illegal <= accept && dec_ill;
            if (mem_busy) begin
                if (flush) vld_p0 <= 1'b0;
            end else begin
                vld_p0    <= accept;
                vld_p1[0] <= vld_p0 && !flush;
                for (int k = 1; k < MEM_LAT; k++) vld_p1[k] <= vld_p1[k-1];
                vld_p2    <= vld_p1[MEM_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!mem_busy) begin
            ctl_p0    <= dec;
            ctl_p1[0] <= ctl_p0.m;
            for (int k = 1; k < MEM_LAT; k++) ctl_p1[k] <= ctl_p1[k-1];
            ctl_p2    <= '{rw: ctl_p1[MEM_LAT-1].rw, m2r: ctl_p1[MEM_LAT-1].m2r,
                           dst: ctl_p1[MEM_LAT-1].dst};
        end
    end

    assign ex_valid        = vld_p0;
    assign ex_alu_ctrl     = vld_p0 ? ctl_p0.alu : 4'd0;
    assign ex_sign_or_zero = vld_p0 && ctl_p0.soz;
    assign ex_lui          = vld_p0 && ctl_p0.lui;

    assign mem_valid       = vld_p1[MEM_LAT-1];
    assign mem_write       = mem_valid ? ctl_p1[MEM_LAT-1].mw : 2'b00;
    assign mem_mask        = mem_valid ? ctl_p1[MEM_LAT-1].mask : '0;

    assign wb_valid        = vld_p2;
    assign wb_reg_write    = vld_p2 && ctl_p2.rw;
    assign wb_mem_to_reg   = vld_p2 && ctl_p2.m2r;
    assign wb_dst          = vld_p2 ? ctl_p2.dst : '0;

endmodule

// File: tb/tb_mips150_ctrl_pipe.sv
// Bench for mips150_ctrl_pipe: three configurations (MEM_LAT=1, MEM_LAT=3, LU_STALL=0 with
// MEM_LAT=2) share one directed stimulus stream and are checked against an instruction-level model.
module tb_mips150_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        mem_busy = 1'b0;
    logic        flush = 1'b0;

    logic       dut_id_ready [3], dut_stall [3], dut_illegal [3];
    logic       dut_ex_valid [3], dut_ex_soz [3], dut_ex_lui [3];
    logic [3:0] dut_ex_alu [3];
    logic       dut_mem_valid [3];
    logic [1:0] dut_mem_write [3];
    logic [2:0] dut_mem_mask [3];
    logic       dut_wb_valid [3], dut_wb_rw [3], dut_wb_m2r [3];
    logic [4:0] dut_wb_dst [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips150_ctrl_pipe #(
            .MEM_LAT  ((g == 1) ? 3 : (g == 2) ? 2 : 1),
            .RADDR_W  (5),
            .MASK_W   (3),
            .LU_STALL ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .instr_valid     (instr_valid),
            .instr           (instr),
            .id_ready        (dut_id_ready[g]),
            .mem_busy        (mem_busy),
            .flush           (flush),
            .stall           (dut_stall[g]),
            .illegal         (dut_illegal[g]),
            .ex_valid        (dut_ex_valid[g]),
            .ex_alu_ctrl     (dut_ex_alu[g]),
            .ex_sign_or_zero (dut_ex_soz[g]),
            .ex_lui          (dut_ex_lui[g]),
            .mem_valid       (dut_mem_valid[g]),
            .mem_write       (dut_mem_write[g]),
            .mem_mask        (dut_mem_mask[g]),
            .wb_valid        (dut_wb_valid[g]),
            .wb_reg_write    (dut_wb_rw[g]),
            .wb_mem_to_reg   (dut_wb_m2r[g]),
            .wb_dst          (dut_wb_dst[g])
        );
    end

    function automatic int mlat(input int k);
        return (k == 1) ? 3 : (k == 2) ? 2 : 1;
    endfunction

    function automatic logic mlus(input int k);
        return k != 2;
    endfunction

    // Expected control word {alu[3:0], soz, lui, mw[1:0], mask[2:0], rw, m2r, dst[4:0]}
    function automatic logic [17:0] mdec(input logic [31:0] ins);
        logic [3:0] alu;
        logic       soz, lui, rw, m2r;
        logic [1:0] mw;
        logic [2:0] mask;
        logic [4:0] dst;
        alu = 4'd0; soz = 1'b0; lui = 1'b0; rw = 1'b0; m2r = 1'b0;
        mw = 2'd0; mask = 3'd0; dst = 5'd0;
        case (ins[31:26])
            6'h00: begin
                rw = 1'b1; dst = ins[15:11];
                case (ins[5:0])
                    6'h22, 6'h23: alu = 4'd1;
                    6'h2A: alu = 4'd2;
                    6'h2B: alu = 4'd3;
                    6'h24: alu = 4'd4;
                    6'h25: alu = 4'd5;
                    6'h26: alu = 4'd6;
                    6'h27: alu = 4'd7;
                    6'h00, 6'h04: alu = 4'd9;
                    6'h02, 6'h06: alu = 4'd10;
                    6'h03, 6'h07: alu = 4'd11;
                    default: alu = 4'd0;
                endcase
            end
            6'h20: begin rw = 1; m2r = 1; soz = 1; dst = ins[20:16]; mask = 3'd0; end
            6'h21: begin rw = 1; m2r = 1; soz = 1; dst = ins[20:16]; mask = 3'd1; end
            6'h23: begin rw = 1; m2r = 1; soz = 1; dst = ins[20:16]; mask = 3'd2; end
            6'h24: begin rw = 1; m2r = 1; soz = 1; dst = ins[20:16]; mask = 3'd3; end
            6'h25: begin rw = 1; m2r = 1; soz = 1; dst = ins[20:16]; mask = 3'd4; end
            6'h28: begin soz = 1; dst = ins[20:16]; mw = 2'd1; end
            6'h29: begin soz = 1; dst = ins[20:16]; mw = 2'd2; end
            6'h2B: begin soz = 1; dst = ins[20:16]; mw = 2'd3; end
            6'h09: begin rw = 1; soz = 1; dst = ins[20:16]; alu = 4'd0; end
            6'h0A: begin rw = 1; soz = 1; dst = ins[20:16]; alu = 4'd2; end
            6'h0B: begin rw = 1; soz = 1; dst = ins[20:16]; alu = 4'd3; end
            6'h0C: begin rw = 1; dst = ins[20:16]; alu = 4'd4; end
            6'h0D: begin rw = 1; dst = ins[20:16]; alu = 4'd5; end
            6'h0E: begin rw = 1; dst = ins[20:16]; alu = 4'd6; end
            6'h0F: begin rw = 1; lui = 1; dst = ins[20:16]; alu = 4'd8; end
            default: ;
        endcase
        return {alu, soz, lui, mw, mask, rw, m2r, dst};
    endfunction

    function automatic logic mill(input logic [31:0] ins);
        case (ins[31:26])
            6'h00, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Model: per configuration, slot 0 = EX, slots 1..L = memory stages, slot L+1 = WB.
    // Each slot is {valid, raw instruction}.
    logic [32:0] st [3][5];
    logic        mill_q [3];

    function automatic logic mstall(input int k);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < mlat(k); j++)
            if (st[k][j][32] && st[k][j][31:29] == 3'b100 && st[k][j][20:16] != 5'd0 &&
                (st[k][j][20:16] == instr[25:21] || st[k][j][20:16] == instr[20:16]))
                hit = 1'b1;
        return mlus(k) && instr_valid && hit;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 5; j++) st[k][j] <= 33'd0;
                mill_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mill_q[k] <= instr_valid && !mstall(k) && !mem_busy && !flush && mill(instr);
                if (mem_busy) begin
                    if (flush) st[k][0][32] <= 1'b0;
                end else begin
                    st[k][mlat(k)+1] <= st[k][mlat(k)];
                    for (int j = 2; j <= mlat(k); j++) st[k][j] <= st[k][j-1];
                    st[k][1] <= flush ? 33'd0 : st[k][0];
                    st[k][0] <= (instr_valid && !mstall(k) && !flush) ? {1'b1, instr} : 33'd0;
                end
            end
        end
    end

    function automatic logic [23:0] expw(input int k);
        logic [32:0] e, m, w;
        logic [17:0] de, dm, dw;
        logic        s;
        e = st[k][0]; m = st[k][mlat(k)]; w = st[k][mlat(k)+1];
        de = mdec(e[31:0]); dm = mdec(m[31:0]); dw = mdec(w[31:0]);
        s = mstall(k);
        return {e[32], e[32] ? de[17:14] : 4'd0, e[32] & de[13], e[32] & de[12],
                m[32], m[32] ? dm[11:10] : 2'd0, m[32] ? dm[9:7] : 3'd0,
                w[32], w[32] & dw[6], w[32] & dw[5], w[32] ? dw[4:0] : 5'd0,
                mill_q[k], s, !s && !mem_busy};
    endfunction

    function automatic logic [23:0] obsw(input int k);
        return {dut_ex_valid[k], dut_ex_alu[k], dut_ex_soz[k], dut_ex_lui[k],
                dut_mem_valid[k], dut_mem_write[k], dut_mem_mask[k],
                dut_wb_valid[k], dut_wb_rw[k], dut_wb_m2r[k], dut_wb_dst[k],
                dut_illegal[k], dut_stall[k], dut_id_ready[k]};
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obsw(k) !== expw(k)) begin
                errors++;
                $display("FAIL model_cmp cfg%0d t=%0t got %h want %h", k, $time, obsw(k), expw(k));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, want);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic b, input logic f);
        @(posedge clk);
        #1;
        instr_valid = v; instr = ins; mem_busy = b; flush = f;
        @(negedge clk);
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int sc3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 32'd0, 0, 0);
        chk("rst_ex_valid", 32'(dut_ex_valid[0]), 32'd0);
        chk("rst_wb_valid", 32'(dut_wb_valid[1]), 32'd0);
        chk("rst_illegal",  32'(dut_illegal[0]), 32'd0);
        chk("rst_id_ready", 32'(dut_id_ready[0]), 32'd1);

        // stream ADDIU, LW, SB, ORI, LUI
        step(1, itype(6'h09, 5'd0, 5'd1, 16'd5), 0, 0);
        chk("s1_ex_empty", 32'(dut_ex_valid[0]), 32'd0);
        step(1, itype(6'h23, 5'd0, 5'd2, 16'd0), 0, 0);
        chk("s1_ex_addiu_alu", 32'(dut_ex_alu[0]), 32'd0);
        chk("s1_ex_addiu_soz", 32'(dut_ex_soz[0]), 32'd1);
        step(1, itype(6'h28, 5'd0, 5'd3, 16'd4), 0, 0);
        step(1, itype(6'h0D, 5'd0, 5'd4, 16'h00FF), 0, 0);
        chk("s1_mem_lw_mask", 32'(dut_mem_mask[0]), 32'd2);
        chk("s1_wb_addiu_rw", 32'(dut_wb_rw[0]), 32'd1);
        chk("s1_wb_addiu_dst", 32'(dut_wb_dst[0]), 32'd1);
        step(1, itype(6'h0F, 5'd0, 5'd5, 16'h1234), 0, 0);
        chk("s1_ex_ori_alu", 32'(dut_ex_alu[0]), 32'd5);
        chk("s1_ex_ori_soz", 32'(dut_ex_soz[0]), 32'd0);
        chk("s1_mem_sb_write", 32'(dut_mem_write[0]), 32'd1);
        chk("s1_wb_lw_m2r", 32'(dut_wb_m2r[0]), 32'd1);
        chk("s1_wb_lw_dst", 32'(dut_wb_dst[0]), 32'd2);
        step(0, 32'd0, 0, 0);
        chk("s1_ex_lui", 32'(dut_ex_lui[0]), 32'd1);
        chk("s1_wb_sb_rw", 32'(dut_wb_rw[0]), 32'd0);
        chk("s1_wb_sb_valid", 32'(dut_wb_valid[0]), 32'd1);
        repeat (5) step(0, 32'd0, 0, 0);

        // load-use: LW $8 then ADDU $9,$8,$10 held until the MEM_LAT=3 unit accepts it
        step(1, itype(6'h23, 5'd0, 5'd8, 16'd0), 0, 0);
        sc3 = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, rtype(5'd8, 5'd10, 5'd9, 6'h21), 0, 0);
            if (dut_stall[1]) sc3++;
            if (i == 0) begin
                chk("lu_stall_ml1", 32'(dut_stall[0]), 32'd1);
                chk("lu_id_ready_ml1", 32'(dut_id_ready[0]), 32'd0);
                chk("lu_nostall_lus0", 32'(dut_stall[2]), 32'd0);
            end
            if (i == 1) chk("lu_release_ml1", 32'(dut_stall[0]), 32'd0);
            if (i == 2) begin
                chk("lu_wb_lw_valid", 32'(dut_wb_valid[0]), 32'd1);
                chk("lu_wb_lw_dst", 32'(dut_wb_dst[0]), 32'd8);
            end
            if (i == 3) chk("lu_wb_bubble", 32'(dut_wb_valid[0]), 32'd0);
        end
        step(0, 32'd0, 0, 0);
        chk("lu_wb_addu_dst", 32'(dut_wb_dst[0]), 32'd9);
        chk("lu_wb_addu_m2r", 32'(dut_wb_m2r[0]), 32'd0);
        chk("lu_bubbles_ml3", 32'(sc3), 32'd3);

        // load to $0 never stalls
        step(1, itype(6'h23, 5'd0, 5'd0, 16'd0), 0, 0);
        step(1, rtype(5'd0, 5'd0, 5'd9, 6'h21), 0, 0);
        chk("z_stall_ml1", 32'(dut_stall[0]), 32'd0);
        chk("z_stall_ml3", 32'(dut_stall[1]), 32'd0);
        repeat (6) step(0, 32'd0, 0, 0);

        // mem_busy for 4 cycles mid-stream
        step(1, itype(6'h09, 5'd0, 5'd11, 16'd1), 0, 0);
        step(1, itype(6'h09, 5'd0, 5'd12, 16'd1), 0, 0);
        step(1, itype(6'h09, 5'd0, 5'd13, 16'd1), 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, itype(6'h09, 5'd0, 5'd14, 16'd1), 1, 0);
            chk("busy_id_ready", 32'(dut_id_ready[0]), 32'd0);
            chk("busy_wb_dst", 32'(dut_wb_dst[0]), 32'd11);
        end
        step(1, itype(6'h09, 5'd0, 5'd14, 16'd1), 0, 0);
        chk("busy_release_ready", 32'(dut_id_ready[0]), 32'd1);
        step(0, 32'd0, 0, 0);
        chk("busy_wb12", 32'(dut_wb_dst[0]), 32'd12);
        step(0, 32'd0, 0, 0);
        chk("busy_wb13", 32'(dut_wb_dst[0]), 32'd13);
        step(0, 32'd0, 0, 0);
        chk("busy_wb14", 32'(dut_wb_dst[0]), 32'd14);
        repeat (5) step(0, 32'd0, 0, 0);

        // flush with an SW while mem_busy
        step(1, itype(6'h09, 5'd0, 5'd15, 16'd1), 0, 0);
        step(1, itype(6'h09, 5'd0, 5'd16, 16'd1), 0, 0);
        step(1, itype(6'h2B, 5'd0, 5'd17, 16'd0), 1, 1);
        step(0, 32'd0, 0, 0);
        chk("fl_ex_cleared", 32'(dut_ex_valid[0]), 32'd0);
        chk("fl_mem_held", 32'(dut_mem_valid[0]), 32'd1);
        step(0, 32'd0, 0, 0);
        chk("fl_wb15_valid", 32'(dut_wb_valid[0]), 32'd1);
        chk("fl_wb15_dst", 32'(dut_wb_dst[0]), 32'd15);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'd0, 0, 0);
            chk("fl_no_sw", 32'(dut_mem_write[0]), 32'd0);
        end
        step(1, itype(6'h09, 5'd0, 5'd18, 16'd1), 0, 1);
        step(0, 32'd0, 0, 0);
        chk("fl_plain", 32'(dut_ex_valid[0]), 32'd0);
        repeat (5) step(0, 32'd0, 0, 0);

        // illegal opcode 3F
        step(1, 32'hFC00_0000, 0, 0);
        step(0, 32'd0, 0, 0);
        chk("ill_pulse", 32'(dut_illegal[0]), 32'd1);
        chk("ill_ex_alu", 32'(dut_ex_alu[0]), 32'd0);
        step(0, 32'd0, 0, 0);
        chk("ill_one_cycle", 32'(dut_illegal[0]), 32'd0);
        step(1, 32'hFC00_0000, 0, 1);
        step(0, 32'd0, 0, 0);
        chk("ill_flushed", 32'(dut_illegal[0]), 32'd0);
        repeat (4) step(0, 32'd0, 0, 0);

        // asynchronous reset mid-stream
        step(1, itype(6'h09, 5'd0, 5'd19, 16'd1), 0, 0);
        step(1, itype(6'h09, 5'd0, 5'd20, 16'd1), 0, 0);
        step(1, itype(6'h09, 5'd0, 5'd21, 16'd1), 0, 0);
        step(1, itype(6'h09, 5'd0, 5'd22, 16'd1), 0, 0);
        #2;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(dut_ex_valid[0]), 32'd0);
        chk("arst_mem_valid", 32'(dut_mem_valid[0]), 32'd0);
        chk("arst_wb_valid", 32'(dut_wb_valid[0]), 32'd0);
        chk("arst_ml3_mem_valid", 32'(dut_mem_valid[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 32'd0, 0, 0);
        chk("arst_id_ready", 32'(dut_id_ready[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 32'd0, 0, 0);
            chk("arst_no_replay", 32'(dut_wb_valid[0]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
